ts_pair_matcher: RTL and testbench
==================================

Name: ts_pair_matcher

Overview:
Sits directly upstream of the UART logger. Pairs start and end event strobes by 16-bit ID and timestamps each strobe from a free-running 64-bit cycle counter. Computes the delta and presents one {id, start_ts, end_ts, delta} record per completed pair on a valid/ready output, which connects straight to the logger's out_* inputs. A small associative table holds open (started but not yet ended) IDs.

Parameters:
SLOTS, 8, number of open-ID table entries (power of two, 2..32)
ID_W, 16, event ID width
TS_W, 64, timestamp/counter width
TS_RESET, 0, counter value loaded on reset (a test hook for wrap-around)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_valid  in  1  start event offered
start_id  in  ID_W  start event ID
start_ready  out  1  start accepted when start_valid && start_ready
end_valid  in  1  end event offered
end_id  in  ID_W  end event ID
end_ready  out  1  end accepted when end_valid && end_ready
out_valid  out  1  record valid
out_ready  in  1  downstream ready
out_id  out  ID_W  matched ID
out_start_ts  out  TS_W  counter value at start handshake
out_end_ts  out  TS_W  counter value at end handshake
out_delta  out  TS_W  out_end_ts - out_start_ts, modulo 2^TS_W
ts_now  out  TS_W  current counter value
drop_count  out  16  unmatched-end counter, saturating

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: ts_now=TS_RESET, all table entries invalid, out_valid=0, out_id/out_start_ts/out_end_ts/out_delta=0, drop_count=0. Reset asserted mid-operation discards all open entries and any pending record.
- Counter: ts_now increments by 1 every non-reset cycle and wraps from all-ones to 0. A handshake in a cycle where ts_now==T captures T.
- Table: each slot holds {valid, id, ts}. The match is combinational over all valid slots. IDs are unique in the table.
- start_ready = !(all slots valid). It does not depend on start_id.
- On start handshake:
  - If start_id hits a valid slot, that slot's ts is overwritten with T (restart).
  - Otherwise the lowest-index invalid slot is allocated with {1, start_id, T}.
- end_ready = !out_valid || out_ready. This is a one-deep output skid.
- On end handshake with a hit in cycle N:
  - The slot is freed.
  - In cycle N+1: out_valid=1, out_id=end_id, out_start_ts=slot ts, out_end_ts=T, out_delta=T-slot ts.
- On end handshake with a miss: no record is produced. drop_count increments and saturates at 0xFFFF.
- Output: out_* are registered. They hold stable while out_valid && !out_ready. out_valid clears the cycle after out_valid && out_ready, unless a new hit loads the register in that same cycle (back-to-back records are allowed at full rate).
- Simultaneous start and end in the same cycle: the end is evaluated against the pre-cycle table.
  - A slot freed by the end is not visible as free to a different-ID start in the same cycle. start_ready uses the pre-cycle fullness.
  - If start_id == end_id and the end hits: the record uses the old ts, and the same slot is immediately re-armed with {1, id, T}.
  - If start_id == end_id and the slot was not present: the end misses (drop), and the start allocates.
- Delta arithmetic is unsigned TS_W-bit subtraction, so it is correct across a single counter wrap.
- No combinational path exists from out_ready to out_* data. end_ready depends combinationally on out_ready only.

Test Plan:
- Basic pair:
  - Stimulus: after reset, start id 0x0012 at ts_now=10, end id 0x0012 at ts_now=25.
  - Response: one cycle later, out_valid=1 with out_id=0x0012, start=10, end=25, delta=0xF. No further records follow.
- Backpressure:
  - Stimulus: out_ready=0, two open IDs 0xABCD and 0x0001, end 0xABCD accepted.
  - Response: end_ready drops, and a pending end 0x0001 stalls. Record fields stay bit-stable for 20 cycles. Raising out_ready delivers 0xABCD, then 0x0001 on the next cycle.
- Table full:
  - Stimulus: 8 starts with IDs 1..8.
  - Response: start_ready=0. A 9th start (ID 9) stalls. End ID 3 is accepted. start_ready=1 the following cycle, and ID 9 occupies slot 2.
- Unmatched end and restart:
  - Stimulus: end ID 0x0055 with no open start; then start 0x0007 at ts 100, start 0x0007 again at ts 140, end at ts 150.
  - Response: drop_count=1 and no record for the first end. The 0x0007 record has start=140, delta=10.
- Wrap-around:
  - Stimulus: TS_RESET=0xFFFF_FFFF_FFFF_FFF0, start at 0xFFFF_FFFF_FFFF_FFF8, end at 0x8.
  - Response: out_delta=0x10.
- Same-cycle start/end and mid-operation reset:
  - Stimulus: start and end of ID 4 in the same cycle with ID 4 open since ts 50, end at ts 60.
  - Response: record delta=10, and ID 4 remains open with ts 60.
  - Stimulus: pulse rst for one cycle.
  - Response: out_valid=0, drop_count=0, start_ready=1. A subsequent end of ID 4 is counted as a drop.

Source files
------------

// File: rtl/ts_pair_matcher_if.sv
`default_nettype none
// ============================================================================
// Module   : ts_pair_matcher_if
// Purpose  : Bundles the start/end event handshakes, the record output
//            handshake and the status outputs of ts_pair_matcher.
// Ports    : start_valid/start_id/start_ready  - start event channel
//            end_valid/end_id/end_ready        - end event channel
//            out_valid/out_ready/out_*         - matched-pair record channel
//            ts_now, drop_count                - status
// Modports : master - event producer / record consumer side
//            slave  - the matcher itself
// Revision : 1.0 - initial release
// ============================================================================
interface ts_pair_matcher_if #(
    parameter int ID_W = 16,
    parameter int TS_W = 64
);
    logic            start_valid;
    logic [ID_W-1:0] start_id;
    logic            start_ready;

    logic            end_valid;
    logic [ID_W-1:0] end_id;
    logic            end_ready;

    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_id;
    logic [TS_W-1:0] out_start_ts;
    logic [TS_W-1:0] out_end_ts;
    logic [TS_W-1:0] out_delta;

    logic [TS_W-1:0] ts_now;
    logic [15:0]     drop_count;

    modport master (
        output start_valid, start_id,
        input  start_ready,
        output end_valid, end_id,
        input  end_ready,
        input  out_valid, out_id, out_start_ts, out_end_ts, out_delta,
        output out_ready,
        input  ts_now, drop_count
    );

    modport slave (
        input  start_valid, start_id,
        output start_ready,
        input  end_valid, end_id,
        output end_ready,
        output out_valid, out_id, out_start_ts, out_end_ts, out_delta,
        input  out_ready,
        output ts_now, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/ts_pair_matcher.sv
`default_nettype none
// ============================================================================
// Module   : ts_pair_matcher
// Purpose  : Pairs start/end event strobes by ID, timestamps each handshake
//            from a free-running counter and emits one {id, start_ts, end_ts,
//            delta} record per completed pair. Open IDs live in a small
//            fully associative table.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            bus  - ts_pair_matcher_if.slave (event inputs, record output,
//                   ts_now and drop_count status)
// Revision : 1.0 - initial release
// ============================================================================
module ts_pair_matcher #(
    parameter int              SLOTS    = 8,
    parameter int              ID_W     = 16,
    parameter int              TS_W     = 64,
    parameter logic [TS_W-1:0] TS_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    ts_pair_matcher_if.slave    bus
);

    localparam int          IDX_W     = $clog2(SLOTS);
    localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

    // Free-running timestamp counter
    logic [TS_W-1:0]  r_ts_now;

    // Open-ID table
    logic [SLOTS-1:0] r_valid;
    logic [ID_W-1:0]  r_id [SLOTS];
    logic [TS_W-1:0]  r_ts [SLOTS];

    // Registered record output
    logic             r_out_valid;
    logic [ID_W-1:0]  r_out_id;
    logic [TS_W-1:0]  r_out_start_ts;
    logic [TS_W-1:0]  r_out_end_ts;
    logic [TS_W-1:0]  r_out_delta;
    logic [15:0]      r_drop_count;

    // Lookup results, all against the table as it stood at the start of the cycle
    logic             w_start_hit;
    logic [IDX_W-1:0] w_start_idx;
    logic             w_end_hit;
    logic [IDX_W-1:0] w_end_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic [TS_W-1:0]  w_end_slot_ts;
    logic             w_full;
    logic             w_start_fire;
    logic             w_end_fire;
    logic             w_load;

    always_comb begin
        w_start_hit = 1'b0;
        w_start_idx = '0;
        w_end_hit   = 1'b0;
        w_end_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (r_valid[i] && (r_id[i] == bus.start_id)) begin
                w_start_hit = 1'b1;
                w_start_idx = IDX_W'(i);
            end
            if (r_valid[i] && (r_id[i] == bus.end_id)) begin
                w_end_hit = 1'b1;
                w_end_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index invalid slot: scan downwards so the lowest index is written last.
    always_comb begin
        w_free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_end_slot_ts = r_ts[w_end_idx];
    assign w_full        = &r_valid;

    // start_ready uses pre-cycle fullness, so a slot freed by a same-cycle
    // end cannot be claimed until the following cycle.
    assign bus.start_ready = !w_full;
    // One-deep skid: an end may be taken whenever the record register is
    // empty or is being drained this cycle.
    assign bus.end_ready   = !r_out_valid || bus.out_ready;

    assign w_start_fire = bus.start_valid && !w_full;
    assign w_end_fire   = bus.end_valid && (!r_out_valid || bus.out_ready);
    assign w_load       = w_end_fire && w_end_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_now       <= TS_RESET;
            r_valid        <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_id[i] <= '0;
                r_ts[i] <= '0;
            end
            r_out_valid    <= 1'b0;
            r_out_id       <= '0;
            r_out_start_ts <= '0;
            r_out_end_ts   <= '0;
            r_out_delta    <= '0;
            r_drop_count   <= '0;
        end else begin
            r_ts_now <= r_ts_now + TS_W'(1);

            // Free on end hit first; a same-ID start below overrides this and
            // re-arms the slot with the current timestamp.
            if (w_load) begin
                r_valid[w_end_idx] <= 1'b0;
            end

            if (w_start_fire) begin
                if (w_start_hit) begin
                    r_valid[w_start_idx] <= 1'b1;
                    r_ts[w_start_idx]    <= r_ts_now;
                end else begin
                    r_valid[w_free_idx]  <= 1'b1;
                    r_id[w_free_idx]     <= bus.start_id;
                    r_ts[w_free_idx]     <= r_ts_now;
                end
            end

            if (w_load) begin
                r_out_valid    <= 1'b1;
                r_out_id       <= bus.end_id;
                r_out_start_ts <= w_end_slot_ts;
                r_out_end_ts   <= r_ts_now;
                // Unsigned modular subtraction stays correct across one wrap.
                r_out_delta    <= r_ts_now - w_end_slot_ts;
            end else if (bus.out_ready) begin
                r_out_valid    <= 1'b0;
            end

            if (w_end_fire && !w_end_hit && (r_drop_count != c_DROP_MAX)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_id       = r_out_id;
    assign bus.out_start_ts = r_out_start_ts;
    assign bus.out_end_ts   = r_out_end_ts;
    assign bus.out_delta    = r_out_delta;
    assign bus.ts_now       = r_ts_now;
    assign bus.drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_ts_pair_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_pair_matcher
// Purpose  : Self-checking bench for ts_pair_matcher. A reference counter and
//            an open-ID table model produce expected records, which are queued
//            at the end handshake and popped when the DUT hands a record over.
//            A second instance with a near-wrap TS_RESET covers counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_pair_matcher;

    localparam logic [63:0] c_WRAP_RESET = 64'hFFFF_FFFF_FFFF_FFF0;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] s;
        logic [63:0] e;
        logic [63:0] d;
    } rec_t;

    logic clk;
    logic rst;

    ts_pair_matcher_if #(.ID_W(16), .TS_W(64)) bus_a ();
    ts_pair_matcher_if #(.ID_W(16), .TS_W(64)) bus_b ();

    ts_pair_matcher #(.SLOTS(8), .ID_W(16), .TS_W(64), .TS_RESET(64'd0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ts_pair_matcher #(.SLOTS(8), .ID_W(16), .TS_W(64), .TS_RESET(c_WRAP_RESET)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    logic [63:0] m_ts;
    logic [63:0] m_ts2;
    logic [63:0] m_open [logic [15:0]];
    rec_t        q [$];

    // Reference counters
    always @(posedge clk) begin
        if (rst) begin
            m_ts  <= 64'd0;
            m_ts2 <= c_WRAP_RESET;
        end else begin
            m_ts  <= m_ts + 64'd1;
            m_ts2 <= m_ts2 + 64'd1;
        end
    end

    // Scoreboard: every delivered record must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            rec_t exp_r;
            rec_t got_r;
            n_cmp++;
            got_r = '{bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta};
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_record: got id=%h start=%h end=%h delta=%h, none expected",
                         got_r.id, got_r.s, got_r.e, got_r.d);
            end else begin
                exp_r = q.pop_front();
                if (got_r !== exp_r) begin
                    n_bad++;
                    $display("FAIL record: got id=%h start=%h end=%h delta=%h, expected id=%h start=%h end=%h delta=%h",
                             got_r.id, got_r.s, got_r.e, got_r.d, exp_r.id, exp_r.s, exp_r.e, exp_r.d);
                end
            end
        end
    end

    // One cycle of stimulus on bus_a; updates the reference table from the
    // observed handshakes (end evaluated before start, against the old table).
    task automatic step(input logic sv, input logic [15:0] sid, input logic ev,
                        input logic [15:0] eid, input logic ordy,
                        output logic s_acc, output logic e_acc);
        logic [63:0] t;
        bus_a.start_valid = sv;
        bus_a.start_id    = sid;
        bus_a.end_valid   = ev;
        bus_a.end_id      = eid;
        bus_a.out_ready   = ordy;
        @(negedge clk);
        s_acc = sv & bus_a.start_ready;
        e_acc = ev & bus_a.end_ready;
        t     = m_ts;
        if (e_acc && m_open.exists(eid)) begin
            q.push_back(rec_t'{eid, m_open[eid], t, t - m_open[eid]});
            m_open.delete(eid);
        end
        if (s_acc) m_open[sid] = t;
        @(posedge clk);
        #1;
        bus_a.start_valid = 1'b0;
        bus_a.end_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        logic sa, ea;
        repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, sa, ea);
    endtask

    // Idle until the next handshake on bus_a (sel=0) or bus_b (sel=1) will capture t.
    task automatic wait_ts(input bit sel, input logic [63:0] t);
        int g;
        g = 0;
        while (((sel ? m_ts2 : m_ts) != t) && (g < 2000)) begin
            idle(1);
            g++;
        end
        if (g >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ts: counter never reached %h", t);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0) && (g < 16)) begin
            idle(1);
            g++;
        end
        idle(2);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records still outstanding, expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        logic sa, ea;
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, sa, ea);
        rst = 1'b0;
        m_open.delete();
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus_a.ts_now !== 64'd0) begin
            n_bad++; $display("FAIL reset_ts_now: got %h expected 0", bus_a.ts_now);
        end
        n_cmp++;
        if (bus_b.ts_now !== c_WRAP_RESET) begin
            n_bad++; $display("FAIL reset_ts_now_b: got %h expected %h", bus_b.ts_now, c_WRAP_RESET);
        end
        n_cmp++;
        if ({bus_a.out_valid, bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got valid=%b id=%h s=%h e=%h d=%h expected all 0",
                              bus_a.out_valid, bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta);
        end
        n_cmp++;
        if (bus_a.drop_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_drop: got %h expected 0", bus_a.drop_count);
        end
        n_cmp++;
        if ({bus_a.start_ready, bus_a.end_ready} !== 2'b11) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 11", {bus_a.start_ready, bus_a.end_ready});
        end
    endtask

    task automatic test_basic_pair();
        logic sa, ea;
        do_reset();
        wait_ts(1'b0, 64'd10);
        step(1'b1, 16'h0012, 1'b0, 16'h0, 1'b1, sa, ea);
        wait_ts(1'b0, 64'd25);
        step(1'b0, 16'h0, 1'b1, 16'h0012, 1'b1, sa, ea);
        n_cmp++;
        if ({bus_a.out_valid, bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta}
            !== {1'b1, 16'h0012, 64'd10, 64'd25, 64'hF}) begin
            n_bad++; $display("FAIL basic_record: got v=%b id=%h s=%0d e=%0d d=%h expected v=1 id=0012 s=10 e=25 d=f",
                              bus_a.out_valid, bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta);
        end
        drain();
        n_cmp++;
        if (bus_a.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_idle: got out_valid=%b expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic sa, ea;
        logic [207:0] held;
        do_reset();
        step(1'b1, 16'hABCD, 1'b0, 16'h0, 1'b0, sa, ea);
        step(1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, sa, ea);
        step(1'b0, 16'h0, 1'b1, 16'hABCD, 1'b0, sa, ea);
        n_cmp++;
        if (ea !== 1'b1) begin
            n_bad++; $display("FAIL bp_first_end: got accepted=%b expected 1", ea);
        end
        held = {bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta};
        n_cmp++;
        if ({bus_a.out_valid, bus_a.end_ready, bus_a.out_id} !== {1'b1, 1'b0, 16'hABCD}) begin
            n_bad++; $display("FAIL bp_stall_state: got v=%b end_ready=%b id=%h expected v=1 end_ready=0 id=abcd",
                              bus_a.out_valid, bus_a.end_ready, bus_a.out_id);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, sa, ea);
            n_cmp++;
            if ((ea !== 1'b0) || (bus_a.out_valid !== 1'b1) ||
                ({bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta} !== held)) begin
                n_bad++; $display("FAIL bp_hold cycle %0d: got accepted=%b v=%b id=%h expected accepted=0 v=1 id=abcd stable",
                                  i, ea, bus_a.out_valid, bus_a.out_id);
            end
        end
        step(1'b0, 16'h0, 1'b1, 16'h0001, 1'b1, sa, ea);
        n_cmp++;
        if ({ea, bus_a.out_valid, bus_a.out_id} !== {1'b1, 1'b1, 16'h0001}) begin
            n_bad++; $display("FAIL bp_back_to_back: got accepted=%b v=%b id=%h expected 1 1 0001",
                              ea, bus_a.out_valid, bus_a.out_id);
        end
        drain();
    endtask

    task automatic test_table_full();
        logic sa, ea;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0, 16'h0, 1'b1, sa, ea);
            n_cmp++;
            if (sa !== 1'b1) begin
                n_bad++; $display("FAIL full_fill id %0d: got accepted=%b expected 1", i, sa);
            end
        end
        step(1'b1, 16'd9, 1'b0, 16'h0, 1'b1, sa, ea);
        n_cmp++;
        if (sa !== 1'b0) begin
            n_bad++; $display("FAIL full_stall: got accepted=%b expected 0", sa);
        end
        step(1'b1, 16'd9, 1'b1, 16'd3, 1'b1, sa, ea);
        n_cmp++;
        if ({sa, ea, bus_a.start_ready} !== 3'b011) begin
            n_bad++; $display("FAIL full_free: got start_acc=%b end_acc=%b start_ready=%b expected 0 1 1",
                              sa, ea, bus_a.start_ready);
        end
        step(1'b1, 16'd9, 1'b0, 16'h0, 1'b1, sa, ea);
        n_cmp++;
        if ({sa, bus_a.start_ready} !== 2'b10) begin
            n_bad++; $display("FAIL full_refill: got accepted=%b start_ready=%b expected 1 0", sa, bus_a.start_ready);
        end
        step(1'b0, 16'h0, 1'b1, 16'd9, 1'b1, sa, ea);
        drain();
    endtask

    task automatic test_drop_restart();
        logic sa, ea;
        do_reset();
        step(1'b0, 16'h0, 1'b1, 16'h0055, 1'b1, sa, ea);
        n_cmp++;
        if ({ea, bus_a.out_valid, bus_a.drop_count} !== {1'b1, 1'b0, 16'd1}) begin
            n_bad++; $display("FAIL drop: got accepted=%b v=%b drop=%0d expected 1 0 1", ea, bus_a.out_valid, bus_a.drop_count);
        end
        wait_ts(1'b0, 64'd100);
        step(1'b1, 16'h0007, 1'b0, 16'h0, 1'b1, sa, ea);
        wait_ts(1'b0, 64'd140);
        step(1'b1, 16'h0007, 1'b0, 16'h0, 1'b1, sa, ea);
        wait_ts(1'b0, 64'd150);
        step(1'b0, 16'h0, 1'b1, 16'h0007, 1'b1, sa, ea);
        n_cmp++;
        if ({bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta}
            !== {16'h0007, 64'd140, 64'd150, 64'd10}) begin
            n_bad++; $display("FAIL restart: got id=%h s=%0d e=%0d d=%0d expected 0007 140 150 10",
                              bus_a.out_id, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        bus_b.out_ready = 1'b1;
        wait_ts(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        bus_b.start_valid = 1'b1;
        bus_b.start_id    = 16'h0021;
        @(posedge clk);
        #1;
        bus_b.start_valid = 1'b0;
        wait_ts(1'b1, 64'd8);
        bus_b.end_valid = 1'b1;
        bus_b.end_id    = 16'h0021;
        @(posedge clk);
        #1;
        bus_b.end_valid = 1'b0;
        n_cmp++;
        if ({bus_b.out_valid, bus_b.out_start_ts, bus_b.out_end_ts, bus_b.out_delta}
            !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 64'h10}) begin
            n_bad++; $display("FAIL wrap: got v=%b s=%h e=%h d=%h expected 1 fffffffffffffff8 8 10",
                              bus_b.out_valid, bus_b.out_start_ts, bus_b.out_end_ts, bus_b.out_delta);
        end
    endtask

    task automatic test_same_cycle_and_reset();
        logic sa, ea;
        do_reset();
        wait_ts(1'b0, 64'd50);
        step(1'b1, 16'h0004, 1'b0, 16'h0, 1'b1, sa, ea);
        wait_ts(1'b0, 64'd60);
        step(1'b1, 16'h0004, 1'b1, 16'h0004, 1'b1, sa, ea);
        n_cmp++;
        if ({sa, ea, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta} !== {2'b11, 64'd50, 64'd60, 64'd10}) begin
            n_bad++; $display("FAIL same_cycle: got acc=%b%b s=%0d e=%0d d=%0d expected 11 50 60 10",
                              sa, ea, bus_a.out_start_ts, bus_a.out_end_ts, bus_a.out_delta);
        end
        wait_ts(1'b0, 64'd75);
        step(1'b0, 16'h0, 1'b1, 16'h0004, 1'b1, sa, ea);
        n_cmp++;
        if ({bus_a.out_start_ts, bus_a.out_delta} !== {64'd60, 64'd15}) begin
            n_bad++; $display("FAIL same_cycle_rearm: got s=%0d d=%0d expected 60 15", bus_a.out_start_ts, bus_a.out_delta);
        end
        drain();
        step(1'b1, 16'h0004, 1'b0, 16'h0, 1'b1, sa, ea);
        step(1'b1, 16'h0006, 1'b0, 16'h0, 1'b1, sa, ea);
        step(1'b0, 16'h0, 1'b1, 16'h0006, 1'b0, sa, ea);
        do_reset();
        n_cmp++;
        if ({bus_a.out_valid, bus_a.drop_count, bus_a.start_ready} !== {1'b0, 16'd0, 1'b1}) begin
            n_bad++; $display("FAIL mid_reset: got v=%b drop=%0d start_ready=%b expected 0 0 1",
                              bus_a.out_valid, bus_a.drop_count, bus_a.start_ready);
        end
        step(1'b0, 16'h0, 1'b1, 16'h0004, 1'b1, sa, ea);
        n_cmp++;
        if ({ea, bus_a.out_valid, bus_a.drop_count} !== {1'b1, 1'b0, 16'd1}) begin
            n_bad++; $display("FAIL post_reset_drop: got accepted=%b v=%b drop=%0d expected 1 0 1",
                              ea, bus_a.out_valid, bus_a.drop_count);
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_a.start_valid = 1'b0;
        bus_a.start_id    = '0;
        bus_a.end_valid   = 1'b0;
        bus_a.end_id      = '0;
        bus_a.out_ready   = 1'b0;
        bus_b.start_valid = 1'b0;
        bus_b.start_id    = '0;
        bus_b.end_valid   = 1'b0;
        bus_b.end_id      = '0;
        bus_b.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_pair();
        test_backpressure();
        test_table_full();
        test_drop_restart();
        test_wrap();
        test_same_cycle_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
